// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and widths for the FIFO consumer-side blocks.
//   state_t      - drain engine state (IDLE / BURST / DRAIN)
//   WORDS_CNT_W  - width of the free-running pull counter
//   REMAIN_W     - width of the per-burst remaining-pull counter
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORDS_CNT_W = 16;
    localparam int REMAIN_W    = 8;

endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: two-entry skid buffer on a valid/ready stream.
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   push, push_data   - write one word at this edge (ignored when full and not popping)
//   out_valid         - buffer holds at least one word
//   out_ready         - downstream accepts out_data at this edge
//   out_data          - oldest buffered word
//   count             - number of buffered words (0..2)
module fifo_skid2 #(
    parameter int WIDTH = 23
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent0;  // oldest
    logic [WIDTH-1:0] ent1;
    logic [1:0]       cnt;
    logic             pop;
    logic             push_ok;

    assign pop     = out_ready && (cnt != 2'd0);
    assign push_ok = push && ((cnt != 2'd2) || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = ent0;
    assign count     = cnt;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drain engine for the consumer side of fifo_buffer.
// Pulls words in bursts of up to BURST_LEN once occupancy reaches the
// threshold, or drains the FIFO to empty on flush, and presents the pulled
// words through a two-entry skid buffer on a valid/ready stream.
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   head, counter         - FIFO front word (FWFT) and registered occupancy
//   pull                  - pops head at this edge
//   threshold             - occupancy that starts a burst (0 acts as 1, > depth never met)
//   flush                 - level request to drain the FIFO completely
//   out_data/out_valid/out_ready - downstream stream
//   busy                  - engine active or skid buffer non-empty
//   words_pulled          - wrapping count of pulls since reset
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BUFFER_WIDTH = 23,
    parameter int BUFFER_DEPTH = 23,
    parameter int BURST_LEN    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] head,
    input  logic [BUFFER_WIDTH-1:0] counter,
    output logic                    pull,
    input  logic [BUFFER_WIDTH-1:0] threshold,
    input  logic                    flush,
    output logic [BUFFER_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [WORDS_CNT_W-1:0]  words_pulled
);

    state_t                  state;
    state_t                  state_nxt;
    logic [REMAIN_W-1:0]     remaining;
    logic                    flush_pending;
    logic [1:0]              skid_count;
    logic [BUFFER_WIDTH-1:0] thr_eff;
    logic                    thr_met;
    logic                    burst_exit;

    // A zero threshold behaves as one; a threshold the FIFO can never hold is never met.
    assign thr_eff    = (threshold == '0) ? BUFFER_WIDTH'(1) : threshold;
    assign thr_met    = (threshold <= BUFFER_WIDTH'(BUFFER_DEPTH)) && (counter >= thr_eff);
    assign burst_exit = (pull && (remaining == REMAIN_W'(1))) || (counter == '0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush)        state_nxt = DRAIN;
                else if (thr_met) state_nxt = BURST;
            end
            BURST: begin
                // A flush arriving on the final burst cycle still leads into DRAIN.
                if (burst_exit) state_nxt = (flush_pending || flush) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if ((counter == '0) && !pull) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: pull depends only on registered terms, never on out_ready.
    always_comb begin
        pull = ((state == BURST) || (state == DRAIN)) && (counter != '0) && (skid_count != 2'd2);
        busy = (state != IDLE) || (skid_count != 2'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining     <= '0;
            flush_pending <= 1'b0;
            words_pulled  <= '0;
        end else begin
            if ((state == IDLE) && (state_nxt == BURST))
                remaining <= REMAIN_W'(BURST_LEN);
            else if ((state == BURST) && pull)
                remaining <= remaining - REMAIN_W'(1);

            if ((state == DRAIN) && (state_nxt == IDLE))
                flush_pending <= 1'b0;
            else if ((state == BURST) && flush)
                flush_pending <= 1'b1;

            if (pull) words_pulled <= words_pulled + WORDS_CNT_W'(1);
        end
    end

    fifo_skid2 #(
        .WIDTH(BUFFER_WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (pull),
        .push_data (head),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (skid_count)
    );

endmodule
